// File: rtl/addatone_pkg.sv
// Shared constants and types for the addatone control path.
// Holds the ADC word width, the default scaler width, the channel index map
// used by control_slew, the control FSM encoding and the harmonic-count clamp.
package addatone_pkg;

  localparam int unsigned ADC_W       = 16;
  localparam int unsigned DIV_BIT_DEF = 11;
  localparam int unsigned CH_W        = 3;

  // Channel index map, one channel per CH cycle
  localparam logic [CH_W-1:0] CH_FREQ    = 3'd0;
  localparam logic [CH_W-1:0] CH_HSCALE0 = 3'd1;
  localparam logic [CH_W-1:0] CH_INIT0   = 3'd2;
  localparam logic [CH_W-1:0] CH_HSCALE1 = 3'd3;
  localparam logic [CH_W-1:0] CH_INIT1   = 3'd4;
  localparam logic [CH_W-1:0] CH_FSCALE  = 3'd5;
  localparam logic [CH_W-1:0] CH_HCOUNT  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CH   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Harmonic count is never zero and never above the ceiling
  function automatic logic [7:0] clamp_hcount(input logic [7:0] raw, input logic [7:0] max_h);
    if (raw == 8'd0) begin
      return 8'd1;
    end else if (raw > max_h) begin
      return max_h;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/slew_step.sv
// slew_step: one slew-rate-limited step from current toward target.
// Ports:
//   i_current  present value
//   i_target   value being approached
//   i_step     largest allowed change
//   o_next_c   combinational next value; lands on target when within one step,
//              otherwise moves exactly one step (never wraps, never overshoots)
module slew_step
  import addatone_pkg::*;
#(
  parameter int unsigned W = ADC_W
) (
  input  logic [W-1:0] i_current,
  input  logic [W-1:0] i_target,
  input  logic [W-1:0] i_step,
  output logic [W-1:0] o_next_c
);

  logic         up;
  logic [W-1:0] mag;

  // Stepping only when mag > step keeps current +/- step inside [0, 2^W)
  always_comb begin
    up  = (i_target >= i_current);
    mag = up ? (i_target - i_current) : (i_current - i_target);
    if (mag <= i_step) begin
      o_next_c = i_target;
    end else if (up) begin
      o_next_c = i_current + i_step;
    end else begin
      o_next_c = i_current - i_step;
    end
  end

endmodule

// File: rtl/control_slew.sv
// control_slew: slew-rate limits the ADC control words feeding the synth core.
// A rising edge of i_Data_Received snapshots all seven ADC words (LOAD), then
// one channel per cycle is stepped toward its snapshot (CH0..CH6), then
// o_Update pulses for one cycle (DONE). Edges seen while busy collapse into a
// single pending pass that starts straight from DONE.
// Ports:
//   i_Clock, i_Reset_n           clock, async active-low reset
//   i_Data0..i_Data6             freq, hscale0, init0, hscale1, init1, freq offset, harmonic count
//   i_Data_Received              frame-complete level from the ADC receiver
//   o_Frequency, o_Freq_Scale    slewed 16-bit frequency and offset
//   o_Harmonic_Scale0/1          slewed scaler controls (DIV_BIT)
//   o_Scale_Initial0/1           slewed scaler initial values (DIV_BIT)
//   o_Harmonic_Count             clamped harmonic count
//   o_Update                     one-cycle pulse after a full pass
//   o_Busy                       high from LOAD through DONE
// Build option: CONTROL_SLEW_HYST_EN holds the frequency channel when the
// target is within 3 counts of the current value (ADC jitter suppression).
// DIV_BIT is assumed to be below 16.
module control_slew
  import addatone_pkg::*;
#(
  parameter int unsigned        DIV_BIT       = DIV_BIT_DEF,
  parameter logic [15:0]        FREQ_STEP     = 16'd64,
  parameter logic [DIV_BIT-1:0] SCALE_STEP    = 11'd16,
  parameter logic [7:0]         MAX_HARMONICS = 8'd100
) (
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  input  logic [15:0]        i_Data0,
  input  logic [15:0]        i_Data1,
  input  logic [15:0]        i_Data2,
  input  logic [15:0]        i_Data3,
  input  logic [15:0]        i_Data4,
  input  logic [15:0]        i_Data5,
  input  logic [15:0]        i_Data6,
  input  logic               i_Data_Received,
  output logic [15:0]        o_Frequency,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale0,
  output logic [DIV_BIT-1:0] o_Scale_Initial0,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale1,
  output logic [DIV_BIT-1:0] o_Scale_Initial1,
  output logic [15:0]        o_Freq_Scale,
  output logic [7:0]         o_Harmonic_Count,
  output logic               o_Update,
  output logic               o_Busy
);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              pend_q, pend_d;
  logic              rcv_q, rcv_d;

  logic [15:0]        sh_freq_q, sh_freq_d;
  logic [DIV_BIT-1:0] sh_hs0_q, sh_hs0_d;
  logic [DIV_BIT-1:0] sh_init0_q, sh_init0_d;
  logic [DIV_BIT-1:0] sh_hs1_q, sh_hs1_d;
  logic [DIV_BIT-1:0] sh_init1_q, sh_init1_d;
  logic [15:0]        sh_fscale_q, sh_fscale_d;
  logic [7:0]         sh_hcount_q, sh_hcount_d;

  logic [15:0]        freq_q, freq_d;
  logic [DIV_BIT-1:0] hs0_q, hs0_d;
  logic [DIV_BIT-1:0] init0_q, init0_d;
  logic [DIV_BIT-1:0] hs1_q, hs1_d;
  logic [DIV_BIT-1:0] init1_q, init1_d;
  logic [15:0]        fscale_q, fscale_d;
  logic [7:0]         hcount_q, hcount_d;
  logic               update_q, update_d;
  logic               busy_q, busy_d;

  logic               data_edge_c;
  logic [ADC_W-1:0]   slew_cur, slew_tgt, slew_sz, slew_next;
  logic               hyst_hold;
  logic               adc_unused_c;

  // Only the low bits of the scaler and count words carry information
  assign adc_unused_c = ^{i_Data1[15:DIV_BIT], i_Data2[15:DIV_BIT], i_Data3[15:DIV_BIT],
                          i_Data4[15:DIV_BIT], i_Data6[15:8]};

  assign data_edge_c = i_Data_Received & ~rcv_q;

  // Operand mux for the single shared slew unit, selected by channel index
  always_comb begin
    slew_cur = freq_q;
    slew_tgt = sh_freq_q;
    slew_sz  = FREQ_STEP;
    case (ch_q)
      CH_HSCALE0: begin
        slew_cur = 16'(hs0_q);
        slew_tgt = 16'(sh_hs0_q);
        slew_sz  = 16'(SCALE_STEP);
      end
      CH_INIT0: begin
        slew_cur = 16'(init0_q);
        slew_tgt = 16'(sh_init0_q);
        slew_sz  = 16'(SCALE_STEP);
      end
      CH_HSCALE1: begin
        slew_cur = 16'(hs1_q);
        slew_tgt = 16'(sh_hs1_q);
        slew_sz  = 16'(SCALE_STEP);
      end
      CH_INIT1: begin
        slew_cur = 16'(init1_q);
        slew_tgt = 16'(sh_init1_q);
        slew_sz  = 16'(SCALE_STEP);
      end
      CH_FSCALE: begin
        slew_cur = fscale_q;
        slew_tgt = sh_fscale_q;
        slew_sz  = FREQ_STEP;
      end
      default: begin
        slew_cur = freq_q;
        slew_tgt = sh_freq_q;
        slew_sz  = FREQ_STEP;
      end
    endcase
  end

  slew_step #(.W(ADC_W)) u_slew_step (
    .i_current (slew_cur),
    .i_target  (slew_tgt),
    .i_step    (slew_sz),
    .o_next_c  (slew_next)
  );

`ifdef CONTROL_SLEW_HYST_EN
  logic [15:0] hyst_mag;

  // Small frequency targets are treated as ADC jitter and ignored
  always_comb begin
    hyst_mag  = (sh_freq_q >= freq_q) ? (sh_freq_q - freq_q) : (freq_q - sh_freq_q);
    hyst_hold = (hyst_mag < 16'd4);
  end
`else
  assign hyst_hold = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pend_d      = pend_q;
    rcv_d       = i_Data_Received;
    sh_freq_d   = sh_freq_q;
    sh_hs0_d    = sh_hs0_q;
    sh_init0_d  = sh_init0_q;
    sh_hs1_d    = sh_hs1_q;
    sh_init1_d  = sh_init1_q;
    sh_fscale_d = sh_fscale_q;
    sh_hcount_d = sh_hcount_q;
    freq_d      = freq_q;
    hs0_d       = hs0_q;
    init0_d     = init0_q;
    hs1_d       = hs1_q;
    init1_d     = init1_q;
    fscale_d    = fscale_q;
    hcount_d    = hcount_q;
    update_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_edge_c) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (data_edge_c) begin
          pend_d = 1'b1;
        end
        sh_freq_d   = i_Data0;
        sh_hs0_d    = i_Data1[DIV_BIT-1:0];
        sh_init0_d  = i_Data2[DIV_BIT-1:0];
        sh_hs1_d    = i_Data3[DIV_BIT-1:0];
        sh_init1_d  = i_Data4[DIV_BIT-1:0];
        sh_fscale_d = i_Data5;
        sh_hcount_d = i_Data6[7:0];
        ch_d        = CH_FREQ;
        state_d     = ST_CH;
      end
      ST_CH: begin
        if (data_edge_c) begin
          pend_d = 1'b1;
        end
        case (ch_q)
          CH_FREQ:    freq_d   = hyst_hold ? freq_q : slew_next;
          CH_HSCALE0: hs0_d    = DIV_BIT'(slew_next);
          CH_INIT0:   init0_d  = DIV_BIT'(slew_next);
          CH_HSCALE1: hs1_d    = DIV_BIT'(slew_next);
          CH_INIT1:   init1_d  = DIV_BIT'(slew_next);
          CH_FSCALE:  fscale_d = slew_next;
          CH_HCOUNT:  hcount_d = clamp_hcount(sh_hcount_q, MAX_HARMONICS);
          default:    ;
        endcase
        if (ch_q == CH_HCOUNT) begin
          state_d  = ST_DONE;
          update_d = 1'b1;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end
      ST_DONE: begin
        // An edge landing on DONE counts as pending
        if (pend_q || data_edge_c) begin
          state_d = ST_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= CH_FREQ;
      pend_q      <= 1'b0;
      rcv_q       <= 1'b0;
      sh_freq_q   <= 16'd0;
      sh_hs0_q    <= '0;
      sh_init0_q  <= '0;
      sh_hs1_q    <= '0;
      sh_init1_q  <= '0;
      sh_fscale_q <= 16'd0;
      sh_hcount_q <= 8'd0;
      freq_q      <= 16'd90;
      hs0_q       <= '0;
      init0_q     <= '0;
      hs1_q       <= '0;
      init1_q     <= '0;
      fscale_q    <= 16'd0;
      hcount_q    <= MAX_HARMONICS;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pend_q      <= pend_d;
      rcv_q       <= rcv_d;
      sh_freq_q   <= sh_freq_d;
      sh_hs0_q    <= sh_hs0_d;
      sh_init0_q  <= sh_init0_d;
      sh_hs1_q    <= sh_hs1_d;
      sh_init1_q  <= sh_init1_d;
      sh_fscale_q <= sh_fscale_d;
      sh_hcount_q <= sh_hcount_d;
      freq_q      <= freq_d;
      hs0_q       <= hs0_d;
      init0_q     <= init0_d;
      hs1_q       <= hs1_d;
      init1_q     <= init1_d;
      fscale_q    <= fscale_d;
      hcount_q    <= hcount_d;
      update_q    <= update_d;
      busy_q      <= busy_d;
    end
  end

  assign o_Frequency       = freq_q;
  assign o_Harmonic_Scale0 = hs0_q;
  assign o_Scale_Initial0  = init0_q;
  assign o_Harmonic_Scale1 = hs1_q;
  assign o_Scale_Initial1  = init1_q;
  assign o_Freq_Scale      = fscale_q;
  assign o_Harmonic_Count  = hcount_q;
  assign o_Update          = update_q;
  assign o_Busy            = busy_q;

endmodule

// File: tb/tb_control_slew.sv
// Directed bench for control_slew: reset values, pass latency, frequency and
// scaler slewing, harmonic clamping, pending-pass collapse, mid-pass reset and
// the optional frequency hysteresis (CONTROL_SLEW_HYST_EN).
module tb_control_slew;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d0, d1, d2, d3, d4, d5, d6;
  logic        rcv;
  logic [15:0] o_freq;
  logic [10:0] o_hs0, o_init0, o_hs1, o_init1;
  logic [15:0] o_fscale;
  logic [7:0]  o_hcount;
  logic        o_upd, o_busy;

  int n_pass  = 0;
  int n_total = 0;

  int          upd_cnt, upd_first, upd_second;
  logic        busy_at [1:24];
  logic [15:0] freq_at [1:24];

  control_slew dut (
    .i_Clock           (clk),
    .i_Reset_n         (rst_n),
    .i_Data0           (d0),
    .i_Data1           (d1),
    .i_Data2           (d2),
    .i_Data3           (d3),
    .i_Data4           (d4),
    .i_Data5           (d5),
    .i_Data6           (d6),
    .i_Data_Received   (rcv),
    .o_Frequency       (o_freq),
    .o_Harmonic_Scale0 (o_hs0),
    .o_Scale_Initial0  (o_init0),
    .o_Harmonic_Scale1 (o_hs1),
    .o_Scale_Initial1  (o_init1),
    .o_Freq_Scale      (o_fscale),
    .o_Harmonic_Count  (o_hcount),
    .o_Update          (o_upd),
    .o_Busy            (o_busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " freq"},   32'(o_freq),   32'd90);
    check({tag, " hs0"},    32'(o_hs0),    32'd0);
    check({tag, " init0"},  32'(o_init0),  32'd0);
    check({tag, " hs1"},    32'(o_hs1),    32'd0);
    check({tag, " init1"},  32'(o_init1),  32'd0);
    check({tag, " fscale"}, 32'(o_fscale), 32'd0);
    check({tag, " hcount"}, 32'(o_hcount), 32'd100);
    check({tag, " update"}, 32'(o_upd),    32'd0);
    check({tag, " busy"},   32'(o_busy),   32'd0);
  endtask

  // Raise i_Data_Received now (at a negedge) and watch 24 cycles; optional
  // extra pulses at e2/e3 and a change of i_Data0 at chg_at (0 disables).
  task automatic run_seq(input int e2, input int e3, input int chg_at, input logic [15:0] chg_val);
    upd_cnt    = 0;
    upd_first  = -1;
    upd_second = -1;
    rcv = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      rcv = (i == e2) || (i == e3);
      if (i == chg_at) d0 = chg_val;
      if (o_upd) begin
        upd_cnt++;
        if (upd_first < 0) upd_first = i;
        else if (upd_second < 0) upd_second = i;
      end
      busy_at[i] = o_busy;
      freq_at[i] = o_freq;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rcv   = 1'b0;
    d0 = 16'd90; d1 = 16'd0; d2 = 16'd0; d3 = 16'd0;
    d4 = 16'd0;  d5 = 16'd0; d6 = 16'd100;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Target equal to the reset frequency: no change, update 9 cycles after edge
    run_seq(0, 0, 0, 16'd0);
    check("p0 freq",       32'(o_freq), 32'd90);
    check("p0 upd_cycle",  32'(upd_first), 32'd9);
    check("p0 upd_count",  32'(upd_cnt), 32'd1);
    check("p0 busy_load",  32'(busy_at[1]), 32'd1);
    check("p0 busy_done",  32'(busy_at[9]), 32'd1);
    check("p0 busy_after", 32'(busy_at[10]), 32'd0);
    check("p0 freq_cyc2",  32'(freq_at[2]), 32'd90);

    // Frequency ramps 64 per update, scalers 16 per update, clamps hold
    d0 = 16'd1000; d1 = 16'd40; d2 = 16'hF805; d3 = 16'h07FF;
    d4 = 16'd0;    d5 = 16'd100; d6 = 16'd0;
    for (int n = 1; n <= 15; n++) begin
      int exp_f;
      run_seq(0, 0, 0, 16'd0);
      exp_f = 90 + 64 * n;
      if (exp_f > 1000) exp_f = 1000;
      check($sformatf("ramp%0d freq", n), 32'(o_freq), 32'(exp_f));
      if (n == 1) begin
        check("ramp1 hs0",    32'(o_hs0),    32'd16);
        check("ramp1 init0",  32'(o_init0),  32'd5);
        check("ramp1 hs1",    32'(o_hs1),    32'd16);
        check("ramp1 init1",  32'(o_init1),  32'd0);
        check("ramp1 fscale", 32'(o_fscale), 32'd64);
        check("ramp1 hcount", 32'(o_hcount), 32'd1);
      end
      if (n == 3) begin
        check("ramp3 hs0",    32'(o_hs0),    32'd40);
        check("ramp3 hs1",    32'(o_hs1),    32'd48);
        check("ramp3 fscale", 32'(o_fscale), 32'd100);
      end
    end
    check("ramp15 hs1", 32'(o_hs1), 32'd240);

    // Downward slew
    d0 = 16'd900;
    run_seq(0, 0, 0, 16'd0);
    check("down freq", 32'(o_freq), 32'd936);

    // Harmonic count clamp and low-byte selection
    d6 = 16'd250;
    run_seq(0, 0, 0, 16'd0);
    check("hc 250", 32'(o_hcount), 32'd100);
    d6 = 16'h0132;
    run_seq(0, 0, 0, 16'd0);
    check("hc 0x132", 32'(o_hcount), 32'd50);

    // Two extra edges during a pass collapse into one pass using its own LOAD values
    d0 = 16'd910;
    run_seq(3, 6, 2, 16'd920);
    check("pend upd_count",  32'(upd_cnt), 32'd2);
    check("pend upd_first",  32'(upd_first), 32'd9);
    check("pend upd_second", 32'(upd_second), 32'd18);
    check("pend freq_mid",   32'(freq_at[10]), 32'd910);
    check("pend busy_mid",   32'(busy_at[10]), 32'd1);
    check("pend freq_end",   32'(o_freq), 32'd920);
    check("pend busy_end",   32'(busy_at[24]), 32'd0);

    // Edge landing on DONE is a pending pass
    d0 = 16'd930;
    run_seq(9, 0, 0, 16'd0);
    check("done_edge upd_count",  32'(upd_cnt), 32'd2);
    check("done_edge upd_second", 32'(upd_second), 32'd18);
    check("done_edge freq",       32'(o_freq), 32'd930);

    // Reset asserted during CH3 aborts the pass immediately
    rcv = 1'b1;
    @(negedge clk);
    rcv = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_upd) upd_cnt++;
    end
    check("abort no_update", 32'(upd_cnt), 32'd0);

    // Fresh pass after release, then ramp to 500 for the hysteresis cases
    d0 = 16'd500;
    run_seq(0, 0, 0, 16'd0);
    check("fresh upd_cycle", 32'(upd_first), 32'd9);
    check("fresh freq",      32'(o_freq), 32'd154);
    for (int n = 0; n < 6; n++) run_seq(0, 0, 0, 16'd0);
    check("hyst base", 32'(o_freq), 32'd500);

    d0 = 16'd503;
    run_seq(0, 0, 0, 16'd0);
`ifdef CONTROL_SLEW_HYST_EN
    check("hyst 503", 32'(o_freq), 32'd500);
`else
    check("hyst 503", 32'(o_freq), 32'd503);
`endif
    d0 = 16'd504;
    run_seq(0, 0, 0, 16'd0);
    check("hyst 504", 32'(o_freq), 32'd504);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
